// File: rtl/event_pkg.sv
// Shared definitions for the event packetizer: 24-bit record layout,
// sync tag and serializer state encoding.
package event_pkg;

  localparam logic [2:0] SYNC_TAG = 3'b101;
  localparam int REC_W     = 24;
  localparam int TS_OFF    = 0;
  localparam int UNIT_OFF  = 16;
  localparam int CODE_OFF  = 18;
  localparam int SPIKE_OFF = 20;
  localparam int TAG_OFF   = 21;
  localparam int B0_OFF    = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_B0   = 2'd1,
    S_B1   = 2'd2,
    S_B2   = 2'd3
  } ser_state_t;

  // The record is stored exactly as its three wire bytes: B0 | ts_hi | ts_lo.
  function automatic logic [REC_W-1:0] pack_record(input logic [1:0]  unit,
                                                   input logic [1:0]  code,
                                                   input logic        spike,
                                                   input logic [15:0] ts);
    logic [REC_W-1:0] rec;
    rec = '0;
    rec[TAG_OFF +: 3]   = SYNC_TAG;
    rec[SPIKE_OFF]      = spike;
    rec[CODE_OFF +: 2]  = code;
    rec[UNIT_OFF +: 2]  = unit;
    rec[TS_OFF +: 16]   = ts;
    return rec;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous record FIFO with show-ahead read data; a push is accepted
// while full when a pop happens in the same cycle.
module event_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [LW-1:0] LVL_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/event_packetizer.sv
// Captures per-unit spike/event edges with a timestamp, arbitrates them
// round-robin into a FIFO and serializes each record as three bytes.
module event_packetizer
  import event_pkg::*;
#(
  parameter int NUM_UNITS  = 4,
  parameter int TS_WIDTH   = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_UNITS-1:0]          spike_detection_array,
  input  logic [2*NUM_UNITS-1:0]        event_out_array,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          overflow,
  output logic [7:0]                    drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam logic [TS_WIDTH-1:0] TS_ONE = 1;

  logic [TS_WIDTH-1:0]    ts;
  logic [NUM_UNITS-1:0]   spike_prev;
  logic [2*NUM_UNITS-1:0] ev_prev;
  logic [NUM_UNITS-1:0]   pending;
  logic [REC_W-1:0]       pend_rec [NUM_UNITS];
  logic [1:0]             rr_ptr;
  logic [NUM_UNITS-1:0]   trigger;
  logic [NUM_UNITS-1:0]   drop;
  logic [2:0]             drop_inc;
  logic [8:0]             drop_sum;
  logic                   grant_valid;
  logic [1:0]             grant_idx;
  logic [1:0]             cand;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_pop;
  logic [REC_W-1:0]       fifo_rd_data;
  ser_state_t             state;
  logic [15:0]            rec_ts;

  always_comb begin
    trigger = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      trigger[i] = ((event_out_array[2*i +: 2] != 2'b00) &&
                    (event_out_array[2*i +: 2] != ev_prev[2*i +: 2])) ||
                   (spike_detection_array[i] && !spike_prev[i]);
    end
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      cand = 2'((int'(rr_ptr) + k) % NUM_UNITS);
      if (!grant_valid && !fifo_full && pending[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // A new trigger on a unit whose old record is being granted is not a drop.
  always_comb begin
    drop     = '0;
    drop_inc = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      drop[i]  = trigger[i] && pending[i] && !(grant_valid && (grant_idx == 2'(i)));
      drop_inc = drop_inc + {2'b00, drop[i]};
    end
    drop_sum = {1'b0, drop_count} + {6'b000000, drop_inc};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts         <= '0;
      spike_prev <= '0;
      ev_prev    <= '0;
      pending    <= '0;
      rr_ptr     <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      ts         <= ts + TS_ONE;
      spike_prev <= spike_detection_array;
      ev_prev    <= event_out_array;
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (trigger[i]) begin
          pending[i] <= 1'b1;
        end else if (grant_valid && (grant_idx == 2'(i))) begin
          pending[i] <= 1'b0;
        end
      end
      if (grant_valid) rr_ptr <= 2'((int'(grant_idx) + 1) % NUM_UNITS);
      if (|drop) begin
        overflow   <= 1'b1;
        drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (trigger[i]) begin
        pend_rec[i] <= pack_record(2'(i), event_out_array[2*i +: 2],
                                   spike_detection_array[i], ts);
      end
    end
  end

  event_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (grant_valid),
    .wr_data (pend_rec[grant_idx]),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign fifo_pop = !fifo_empty && ((state == S_IDLE) || ((state == S_B2) && out_ready));

  // Back-to-back records go straight from B2 to B0 to sustain one record per 3 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      rec_ts    <= '0;
    end else begin
      case (state)
        S_IDLE, S_B2: begin
          if (fifo_pop) begin
            state     <= S_B0;
            out_valid <= 1'b1;
            out_data  <= fifo_rd_data[B0_OFF +: 8];
            rec_ts    <= fifo_rd_data[TS_OFF +: 16];
          end else if (state == S_B2 && out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
          end
        end
        S_B0: begin
          if (out_ready) begin
            state    <= S_B1;
            out_data <= rec_ts[15:8];
          end
        end
        S_B1: begin
          if (out_ready) begin
            state    <= S_B2;
            out_data <= rec_ts[7:0];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
